// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer round controller.
package reaction_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      GO     = 2'd2,
      RESULT = 2'd3
   } state_t;

   // Default widths of the random source and the time values.
   localparam int LFSR_W_DEF = 12;
   localparam int CNT_W_DEF  = 24;

   // Feedback taps for x^12 + x^6 + x^4 + x + 1 on a shift-left register:
   // bits 11, 5, 3 and 0 are XORed into the new bit 0.
   localparam logic [LFSR_W_DEF-1:0] LFSR_TAPS = 12'h829;

   // "No time recorded yet" marker for the best-time register.
   localparam logic [CNT_W_DEF-1:0] CNT_ALL_ONES = '1;

endpackage

// File: rtl/lfsr_rand.sv
// Free-running Fibonacci LFSR used as the random delay source.
// Seeded with 1 so the register can never reach the all-zero lock-up state.
module lfsr_rand
   import reaction_pkg::*;
#(
   parameter int                LFSR_W = LFSR_W_DEF,
   parameter logic [LFSR_W-1:0] TAPS   = LFSR_TAPS
) (
   input  logic              cin,
   input  logic              reset,
   output logic [LFSR_W-1:0] q
);

   // Shift left every cycle, feeding back the XOR of the tapped bits.
   always_ff @(posedge cin) begin
      if (reset) begin
         q <= LFSR_W'(1);
      end else begin
         q <= {q[LFSR_W-2:0], ^(q & TAPS)};
      end
   end

endmodule

// File: rtl/reaction_round_ctrl.sv
// Reaction-timer round controller: random pre-delay, LED GO phase, tick-based
// reaction measurement with false-start and timeout handling, plus best-time
// and per-set average tracking for the score/display blocks.
module reaction_round_ctrl
   import reaction_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int NUM_LEDS    = 10,
   parameter int LFSR_W      = LFSR_W_DEF,
   parameter int DELAY_BITS  = 10,
   parameter int MIN_DELAY   = 500,
   parameter int TIMEOUT     = 5000,
   parameter int ROUNDS_LOG2 = 2
) (
   input  logic                   cin,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   start_stop,
   input  logic                   tick,
   input  logic                   clear_best,
   output logic [NUM_LEDS-1:0]    light,
   output logic                   activation,
   output logic                   false_start,
   output logic [CNT_W-1:0]       reaction_time,
   output logic                   time_valid,
   output logic [CNT_W-1:0]       best_time,
   output logic [CNT_W-1:0]       avg_time,
   output logic                   avg_valid,
   output logic [ROUNDS_LOG2-1:0] round_idx
);

   localparam int SUM_W = CNT_W + ROUNDS_LOG2;

   localparam logic [CNT_W-1:0]  MIN_DELAY_C = CNT_W'(MIN_DELAY);
   localparam logic [CNT_W-1:0]  TIMEOUT_C   = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0]  NO_TIME     = {CNT_W{1'b1}};
   localparam logic [LFSR_W-1:0] RAND_MASK   = LFSR_W'((1 << DELAY_BITS) - 1);

   state_t                 state;
   state_t                 next_state;

   logic [LFSR_W-1:0]      lfsr_q;
   logic [CNT_W-1:0]       rand_delay;

   logic [CNT_W-1:0]       delay_cnt;
   logic [CNT_W-1:0]       delay_nxt;
   logic [CNT_W-1:0]       time_cnt;
   logic [CNT_W-1:0]       time_nxt;

   logic                   rec_en;
   logic [CNT_W-1:0]       rec_val;
   logic                   fs_set;
   logic                   fs_clr;

   logic [SUM_W-1:0]       sum;
   logic [SUM_W-1:0]       sum_add;
   logic                   set_done;

   lfsr_rand #(
      .LFSR_W (LFSR_W),
      .TAPS   (LFSR_TAPS)
   ) u_lfsr (
      .cin   (cin),
      .reset (reset),
      .q     (lfsr_q)
   );

   // Masking keeps only the low DELAY_BITS of the LFSR as the random offset.
   assign rand_delay = CNT_W'(lfsr_q & RAND_MASK);

   // Round accumulation: the last round of a set closes it out.
   assign sum_add  = sum + SUM_W'(rec_val);
   assign set_done = (round_idx == {ROUNDS_LOG2{1'b1}});

   // State register.
   always_ff @(posedge cin) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic, delay/time counter updates and round-record requests.
   always_comb begin
      next_state = state;
      delay_nxt  = delay_cnt;
      time_nxt   = time_cnt;
      rec_en     = 1'b0;
      rec_val    = time_cnt;
      fs_set     = 1'b0;
      fs_clr     = 1'b0;

      if (!enable) begin
         next_state = IDLE;
         delay_nxt  = '0;
         time_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_stop) begin
                  delay_nxt  = MIN_DELAY_C + rand_delay;
                  fs_clr     = 1'b1;
                  next_state = WAIT;
               end
            end

            WAIT: begin
               // A press before the lights wins even on the expiry tick.
               if (start_stop) begin
                  fs_set     = 1'b1;
                  delay_nxt  = '0;
                  next_state = IDLE;
               end else if (tick) begin
                  if (delay_cnt == '0) begin
                     time_nxt   = '0;
                     next_state = GO;
                  end else begin
                     delay_nxt = delay_cnt - CNT_W'(1);
                  end
               end
            end

            GO: begin
               // Stop records the count before any coincident tick lands.
               if (start_stop) begin
                  rec_en     = 1'b1;
                  rec_val    = time_cnt;
                  next_state = RESULT;
               end else if (tick) begin
                  if (time_cnt == TIMEOUT_C - CNT_W'(1)) begin
                     rec_en     = 1'b1;
                     rec_val    = TIMEOUT_C;
                     next_state = RESULT;
                  end else begin
                     time_nxt = time_cnt + CNT_W'(1);
                  end
               end
            end

            RESULT: begin
               next_state = IDLE;
            end

            default: begin
               next_state = IDLE;
            end
         endcase
      end
   end

   // Delay and reaction counters.
   always_ff @(posedge cin) begin
      if (reset) begin
         delay_cnt <= '0;
         time_cnt  <= '0;
      end else begin
         delay_cnt <= delay_nxt;
         time_cnt  <= time_nxt;
      end
   end

   // Registered LED bank and activation, high for exactly the GO cycles.
   always_ff @(posedge cin) begin
      if (reset) begin
         light      <= '0;
         activation <= 1'b0;
      end else begin
         light      <= {NUM_LEDS{next_state == GO}};
         activation <= (next_state == GO);
      end
   end

   // False-start flag: set by an early press, cleared by the next start.
   always_ff @(posedge cin) begin
      if (reset) begin
         false_start <= 1'b0;
      end else if (fs_set) begin
         false_start <= 1'b1;
      end else if (fs_clr) begin
         false_start <= 1'b0;
      end
   end

   // Round result, running sum, set index and average; results land on the
   // edge into RESULT so time_valid is high during the RESULT cycle.
   always_ff @(posedge cin) begin
      if (reset) begin
         reaction_time <= '0;
         time_valid    <= 1'b0;
         avg_time      <= '0;
         avg_valid     <= 1'b0;
         round_idx     <= '0;
         sum           <= '0;
      end else begin
         time_valid <= 1'b0;
         avg_valid  <= 1'b0;
         if (rec_en) begin
            reaction_time <= rec_val;
            time_valid    <= 1'b1;
            round_idx     <= round_idx + ROUNDS_LOG2'(1);
            if (set_done) begin
               avg_time  <= CNT_W'(sum_add >> ROUNDS_LOG2);
               avg_valid <= 1'b1;
               sum       <= '0;
            end else begin
               sum <= sum_add;
            end
         end
      end
   end

   // Best time: a coincident result beats a clear, otherwise strict minimum.
   always_ff @(posedge cin) begin
      if (reset) begin
         best_time <= NO_TIME;
      end else if (rec_en && (clear_best || (rec_val < best_time))) begin
         best_time <= rec_val;
      end else if (clear_best) begin
         best_time <= NO_TIME;
      end
   end

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Scenario bench for reaction_round_ctrl with a reaction-time scoreboard.
module tb_reaction_round_ctrl;

   localparam int CNT_W    = 24;
   localparam int NUM_LEDS = 10;
   localparam int RL2      = 2;
   localparam int TO       = 20;

   logic                cin = 1'b0;
   logic                reset = 1'b1;
   logic                enable = 1'b1;
   logic                start_stop = 1'b0;
   logic                tick = 1'b1;
   logic                clear_best = 1'b0;
   logic [NUM_LEDS-1:0] light;
   logic                activation;
   logic                false_start;
   logic [CNT_W-1:0]    reaction_time;
   logic                time_valid;
   logic [CNT_W-1:0]    best_time;
   logic [CNT_W-1:0]    avg_time;
   logic                avg_valid;
   logic [RL2-1:0]      round_idx;

   int checks = 0;
   int errors = 0;
   int tv_count = 0;
   int av_count = 0;

   logic [CNT_W-1:0] exp_q[$];
   logic [CNT_W-1:0] exp_v;

   localparam logic [CNT_W-1:0] ONES = {CNT_W{1'b1}};

   reaction_round_ctrl #(
      .CNT_W       (CNT_W),
      .NUM_LEDS    (NUM_LEDS),
      .LFSR_W      (12),
      .DELAY_BITS  (2),
      .MIN_DELAY   (2),
      .TIMEOUT     (TO),
      .ROUNDS_LOG2 (RL2)
   ) dut (
      .cin           (cin),
      .reset         (reset),
      .enable        (enable),
      .start_stop    (start_stop),
      .tick          (tick),
      .clear_best    (clear_best),
      .light         (light),
      .activation    (activation),
      .false_start   (false_start),
      .reaction_time (reaction_time),
      .time_valid    (time_valid),
      .best_time     (best_time),
      .avg_time      (avg_time),
      .avg_valid     (avg_valid),
      .round_idx     (round_idx)
   );

   always #5 cin = ~cin;

   // Scoreboard: every time_valid pulse pops and compares the oldest expectation.
   always @(negedge cin) begin
      if (time_valid) begin
         tv_count++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_unexpected: reaction_time=%0d, none expected", reaction_time);
         end else begin
            exp_v = exp_q.pop_front();
            if (reaction_time !== exp_v) begin
               errors++;
               $display("FAIL scoreboard_time: got %0d, expected %0d", reaction_time, exp_v);
            end
         end
      end
      if (avg_valid) av_count++;
   end

   task automatic step;
      @(posedge cin);
      #1;
   endtask

   task automatic pulse_start;
      start_stop = 1'b1;
      step();
      start_stop = 1'b0;
   endtask

   task automatic wait_act(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         if (activation) ok = 1'b1;
         else step();
      end
   endtask

   task automatic run_round(input int t);
      bit ok;
      pulse_start();
      wait_act(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL round_go_timeout: activation=%0b, expected 1 within 40 cycles", activation);
      end
      repeat (t) step();
      exp_q.push_back(CNT_W'(t));
      pulse_start();
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      step();
      checks++;
      if ({light, activation, false_start, time_valid, avg_valid} !== '0) begin
         errors++;
         $display("FAIL reset_flags: light=%h act=%0b fs=%0b tv=%0b av=%0b, expected all 0",
                  light, activation, false_start, time_valid, avg_valid);
      end
      checks++;
      if (reaction_time !== '0 || avg_time !== '0 || round_idx !== '0) begin
         errors++;
         $display("FAIL reset_values: rt=%0d avg=%0d idx=%0d, expected 0 0 0",
                  reaction_time, avg_time, round_idx);
      end
      checks++;
      if (best_time !== 24'hFFFFFF) begin
         errors++;
         $display("FAIL reset_best: got %h, expected ffffff", best_time);
      end
   endtask

   task automatic test_single;
      bit ok;
      pulse_start();
      wait_act(ok);
      checks++;
      if (!ok || light !== 10'h3FF) begin
         errors++;
         $display("FAIL single_go: act=%0b light=%h, expected 1 3ff", activation, light);
      end
      repeat (7) step();
      exp_q.push_back(CNT_W'(7));
      pulse_start();
      checks++;
      if (time_valid !== 1'b1) begin
         errors++;
         $display("FAIL single_valid: time_valid=%0b, expected 1", time_valid);
      end
      checks++;
      if (best_time !== CNT_W'(7) || round_idx !== 2'd1) begin
         errors++;
         $display("FAIL single_score: best=%0d idx=%0d, expected 7 1", best_time, round_idx);
      end
      step();
      checks++;
      if (time_valid !== 1'b0 || light !== '0 || activation !== 1'b0) begin
         errors++;
         $display("FAIL single_after: tv=%0b light=%h act=%0b, expected 0 000 0",
                  time_valid, light, activation);
      end
   endtask

   task automatic test_false_start;
      int tv0;
      tv0 = tv_count;
      pulse_start();
      step();
      pulse_start();
      checks++;
      if (false_start !== 1'b1) begin
         errors++;
         $display("FAIL false_start_set: got %0b, expected 1", false_start);
      end
      repeat (20) step();
      checks++;
      if (activation !== 1'b0 || false_start !== 1'b1 || tv_count != tv0 || round_idx !== 2'd1) begin
         errors++;
         $display("FAIL false_start_hold: act=%0b fs=%0b results=%0d idx=%0d, expected 0 1 %0d 1",
                  activation, false_start, tv_count, round_idx, tv0);
      end
      pulse_start();
      checks++;
      if (false_start !== 1'b0) begin
         errors++;
         $display("FAIL false_start_clear: got %0b, expected 0", false_start);
      end
   endtask

   // Continues from the round started at the end of test_false_start.
   task automatic test_timeout;
      bit ok;
      wait_act(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL timeout_go: activation=%0b, expected 1", activation);
      end
      exp_q.push_back(CNT_W'(TO));
      repeat (TO - 1) step();
      checks++;
      if (time_valid !== 1'b0 || activation !== 1'b1) begin
         errors++;
         $display("FAIL timeout_early: tv=%0b act=%0b, expected 0 1", time_valid, activation);
      end
      step();
      checks++;
      if (time_valid !== 1'b1 || activation !== 1'b0) begin
         errors++;
         $display("FAIL timeout_end: tv=%0b act=%0b, expected 1 0", time_valid, activation);
      end
      checks++;
      if (round_idx !== 2'd2 || best_time !== CNT_W'(7)) begin
         errors++;
         $display("FAIL timeout_score: idx=%0d best=%0d, expected 2 7", round_idx, best_time);
      end
      step();
   endtask

   task automatic test_average;
      int times[4] = '{4, 8, 12, 16};
      int total;
      int av0;
      total = 0;
      reset = 1'b1;
      repeat (2) step();
      reset = 1'b0;
      step();
      av0 = av_count;
      for (int k = 0; k < 4; k++) begin
         run_round(times[k]);
         total += times[k];
         checks++;
         if (round_idx !== RL2'((k + 1) % 4)) begin
            errors++;
            $display("FAIL avg_idx_%0d: got %0d, expected %0d", k, round_idx, (k + 1) % 4);
         end
         checks++;
         if (k < 3 && avg_valid !== 1'b0) begin
            errors++;
            $display("FAIL avg_early_%0d: avg_valid=%0b, expected 0", k, avg_valid);
         end else if (k == 3 && (avg_valid !== 1'b1 || avg_time !== CNT_W'(total >> RL2))) begin
            errors++;
            $display("FAIL avg_value: av=%0b avg=%0d, expected 1 %0d", avg_valid, avg_time, total >> RL2);
         end
         step();
      end
      checks++;
      if (av_count != av0 + 1 || best_time !== CNT_W'(4)) begin
         errors++;
         $display("FAIL avg_summary: pulses=%0d best=%0d, expected 1 4", av_count - av0, best_time);
      end
   endtask

   task automatic test_enable_low;
      bit ok;
      int tv0;
      tv0 = tv_count;
      pulse_start();
      wait_act(ok);
      enable = 1'b0;
      step();
      checks++;
      if (!ok || activation !== 1'b0 || light !== '0) begin
         errors++;
         $display("FAIL enable_abort: reached_go=%0b act=%0b light=%h, expected 1 0 000",
                  ok, activation, light);
      end
      checks++;
      if (best_time !== CNT_W'(4) || round_idx !== 2'd0 || avg_time !== CNT_W'(10)) begin
         errors++;
         $display("FAIL enable_retain: best=%0d idx=%0d avg=%0d, expected 4 0 10",
                  best_time, round_idx, avg_time);
      end
      enable = 1'b1;
      repeat (30) step();
      checks++;
      if (activation !== 1'b0 || tv_count != tv0) begin
         errors++;
         $display("FAIL enable_idle: act=%0b results=%0d, expected 0 %0d", activation, tv_count, tv0);
      end
   endtask

   task automatic test_clear_best;
      clear_best = 1'b1;
      step();
      clear_best = 1'b0;
      checks++;
      if (best_time !== ONES) begin
         errors++;
         $display("FAIL clear_best: got %h, expected ffffff", best_time);
      end
      run_round(9);
      checks++;
      if (best_time !== CNT_W'(9) || round_idx !== 2'd1) begin
         errors++;
         $display("FAIL clear_then_round: best=%0d idx=%0d, expected 9 1", best_time, round_idx);
      end
      step();
   endtask

   task automatic test_reset_mid;
      bit ok;
      pulse_start();
      wait_act(ok);
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if (!ok || activation !== 1'b0 || best_time !== ONES || round_idx !== 2'd0 || time_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: reached_go=%0b act=%0b best=%h idx=%0d tv=%0b, expected 1 0 ffffff 0 0",
                  ok, activation, best_time, round_idx, time_valid);
      end
      repeat (5) step();
   endtask

   initial begin
      test_reset();
      test_single();
      test_false_start();
      test_timeout();
      test_average();
      test_enable_low();
      test_clear_best();
      test_reset_mid();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover: %0d results missing, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
